// File: rtl/logic_reduce_unit_pkg.sv
// logic_reduce_unit_pkg: op codes, FSM states and op decode helpers for logic_reduce_unit
package logic_reduce_unit_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;
  function automatic logic is_inverting(input logic [2:0] op);
    return op == OP_NAND || op == OP_NOR || op == OP_XNOR;
  endfunction
  function automatic logic [1:0] base_sel(input logic [2:0] op);
    return op >= OP_NAND ? 2'(op - OP_NAND) : op[1:0];
  endfunction
endpackage

// File: rtl/logic_reduce_unit_gate.sv
// bitwise_gate_core: combinational WIDTH-bit AND/OR/XOR selected by sel (0 AND, 1 OR, else XOR)
module bitwise_gate_core #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  always_comb y = sel == 2'd0 ? a & b : sel == 2'd1 ? a | b : a ^ b;
endmodule

// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: streaming bitwise reduction of an operand stream with optional final inversion
module logic_reduce_unit
  import logic_reduce_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_err
);
  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n, gate_y, res;
  logic [2:0]       op_q, op_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       sel;
  logic             first, in_fire, rsv;
  assign sel = base_sel(op_q);
  bitwise_gate_core #(.WIDTH(WIDTH)) u_gate (.sel(sel), .a(acc), .b(in_data), .y(gate_y));
  always_comb begin
    in_ready  = state != S_OUT;
    out_valid = state == S_OUT;
    in_fire   = in_valid && in_ready;
    first     = state == S_IDLE;
    op_n      = first ? in_op : op_q;
    acc_n     = first ? in_data : gate_y;
    cnt_n     = first ? CNT_W'(1) : &cnt ? cnt : cnt + CNT_W'(1);
    rsv       = op_n > OP_XNOR;
    res       = rsv ? '0 : is_inverting(op_n) ? ~acc_n : acc_n;
    state_n   = state == S_OUT ? (out_ready ? S_IDLE : S_OUT) :
                in_fire ? (in_last ? S_OUT : S_ACCUM) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_cnt  <= '0;
      out_err  <= 1'b0;
    end else begin
      state <= state_n;
      if (in_fire) begin
        acc  <= acc_n;
        op_q <= op_n;
        cnt  <= cnt_n;
      end
      if (in_fire && in_last) begin
        out_data <= res;
        out_cnt  <= cnt_n;
        out_err  <= rsv;
      end
    end
  end
endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb_logic_reduce_unit: scoreboard bench for logic_reduce_unit
module tb_logic_reduce_unit;
  logic       clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_data = 0;
  logic [2:0] in_op = 0;
  logic       in_ready, out_valid, out_err;
  logic [7:0] out_data;
  logic [3:0] out_cnt;
  typedef struct packed {logic [7:0] d; logic [3:0] c; logic e;} exp_t;
  exp_t       sb[$];
  logic [7:0] beats[64];
  int         tests = 0, fails = 0;
  logic_reduce_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_err(out_err)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [2:0] op, input int n);
    logic [7:0] a = beats[0];
    for (int i = 1; i < n; i++)
      case (op % 3)
        0: a = a & beats[i];
        1: a = a | beats[i];
        default: a = a ^ beats[i];
      endcase
    if (op > 3'd5) a = 8'h00;
    else if (op >= 3'd3) a = ~a;
    return {a, 4'(n > 15 ? 15 : n), op > 3'd5};
  endfunction
  task automatic send_txn(input logic [2:0] op, input int n, input bit gap, input bit close);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data  = beats[i];
      in_op    = i == 0 ? op : ~op;
      in_last  = close && i == n - 1;
      w = 0;
      while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin tests++; fails++; $display("FAIL send_ready: in_ready=%b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 0;
      in_last  = 0;
      in_data  = 8'($urandom);
      if (gap && i < n - 1) begin @(posedge clk); #1; end
    end
  endtask
  task automatic get_result(output exp_t r);
    int w = 0;
    while (!out_valid && w < 50) begin @(posedge clk); #1; w++; end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL result_timeout: out_valid=%b want 1", out_valid);
      r = 'x;
    end else begin
      r = {out_data, out_cnt, out_err};
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset();
    rst = 1; in_valid = 1; in_last = 1; in_data = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, out_data, out_cnt, out_err} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b data=%h cnt=%0d err=%b want 1 0 00 0 0", in_ready, out_valid, out_data, out_cnt, out_err);
    end
    rst = 0; in_valid = 0; in_last = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_nor();
    logic [7:0] a[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] b[4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] y[4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    exp_t r, e;
    for (int i = 0; i < 4; i++) begin
      beats[0] = a[i]; beats[1] = b[i];
      sb.push_back({y[i], 4'd2, 1'b0});
      send_txn(3'd4, 2, 0, 1);
      get_result(r);
      e = sb.pop_front();
      tests++;
      if (r !== e) begin fails++; $display("FAIL nor%0d: got %h/%0d/%b want %h/%0d/%b", i, r.d, r.c, r.e, e.d, e.c, e.e); end
    end
  endtask
  task automatic test_multi();
    exp_t r, e;
    beats[0] = 8'hFF; beats[1] = 8'hF0; beats[2] = 8'hFC; beats[3] = 8'hF8;
    sb.push_back({8'h0F, 4'd4, 1'b0});
    send_txn(3'd3, 4, 0, 1);
    get_result(r);
    e = sb.pop_front();
    tests++;
    if (r !== e) begin fails++; $display("FAIL nand4: got %h/%0d/%b want %h/%0d/%b", r.d, r.c, r.e, e.d, e.c, e.e); end
    beats[0] = 8'h01; beats[1] = 8'h02; beats[2] = 8'h04; beats[3] = 8'h08;
    sb.push_back({8'h0F, 4'd4, 1'b0});
    send_txn(3'd2, 4, 0, 1);
    get_result(r);
    e = sb.pop_front();
    tests++;
    if (r !== e) begin fails++; $display("FAIL xor4: got %h/%0d/%b want %h/%0d/%b", r.d, r.c, r.e, e.d, e.c, e.e); end
  endtask
  task automatic test_backpressure();
    out_ready = 0;
    beats[0] = 8'hF0; beats[1] = 8'h3C;
    send_txn(3'd0, 2, 0, 1);
    in_valid = 1; in_data = 8'hAA; in_op = 3'd1; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({out_valid, in_ready, out_data, out_cnt} !== {1'b1, 1'b0, 8'h30, 4'd2}) begin
        fails++;
        $display("FAIL hold%0d: vld=%b rdy=%b data=%h cnt=%0d want 1 0 30 2", i, out_valid, in_ready, out_data, out_cnt);
      end
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL release: rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL no_consume: vld=%b want 0", out_valid); end
  endtask
  task automatic test_gap_reserved();
    exp_t r, e;
    beats[0] = 8'h01; beats[1] = 8'h10; beats[2] = 8'h80;
    sb.push_back({8'h91, 4'd3, 1'b0});
    send_txn(3'd1, 3, 1, 1);
    get_result(r);
    e = sb.pop_front();
    tests++;
    if (r !== e) begin fails++; $display("FAIL or_gap: got %h/%0d/%b want %h/%0d/%b", r.d, r.c, r.e, e.d, e.c, e.e); end
    beats[0] = 8'h12; beats[1] = 8'h34;
    sb.push_back({8'h00, 4'd2, 1'b1});
    send_txn(3'd6, 2, 0, 1);
    get_result(r);
    e = sb.pop_front();
    tests++;
    if (r !== e) begin fails++; $display("FAIL reserved: got %h/%0d/%b want %h/%0d/%b", r.d, r.c, r.e, e.d, e.c, e.e); end
  endtask
  task automatic test_reset_mid();
    exp_t r, e;
    beats[0] = 8'h11; beats[1] = 8'h22;
    send_txn(3'd1, 2, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin fails++; $display("FAIL reset_mid: vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    beats[0] = 8'h5A;
    sb.push_back({8'h5A, 4'd1, 1'b0});
    send_txn(3'd0, 1, 0, 1);
    get_result(r);
    e = sb.pop_front();
    tests++;
    if (r !== e) begin fails++; $display("FAIL after_reset: got %h/%0d/%b want %h/%0d/%b", r.d, r.c, r.e, e.d, e.c, e.e); end
  endtask
  task automatic test_saturation();
    exp_t r, e;
    for (int i = 0; i < 20; i++) beats[i] = 8'($urandom);
    sb.push_back(model(3'd2, 20));
    send_txn(3'd2, 20, 0, 1);
    get_result(r);
    e = sb.pop_front();
    tests++;
    if (r !== e || r.c !== 4'd15) begin fails++; $display("FAIL saturate: got %h/%0d/%b want %h/15/%b", r.d, r.c, r.e, e.d, e.e); end
  endtask
  task automatic test_back_to_back();
    exp_t r, e;
    logic [2:0] op;
    int n;
    for (int t = 0; t < 8; t++) begin
      op = 3'($urandom_range(0, 7));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) beats[i] = 8'($urandom);
      sb.push_back(model(op, n));
      send_txn(op, n, t[0], 1);
      get_result(r);
      e = sb.pop_front();
      tests++;
      if (r !== e) begin fails++; $display("FAIL b2b%0d op%0d n%0d: got %h/%0d/%b want %h/%0d/%b", t, op, n, r.d, r.c, r.e, e.d, e.c, e.e); end
    end
  endtask
  initial begin
    test_reset();
    test_nor();
    test_multi();
    test_backpressure();
    test_gap_reserved();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/logic_reduce_unit.md
Name: logic_reduce_unit

Overview:
- Streaming, parametrised successor to the two-input gate primitives: reduces a variable-length stream of WIDTH-bit operands with one selectable bitwise gate function (AND/OR/XOR/NAND/NOR/XNOR).
- Handles one operand per cycle on a valid/ready input and returns one registered result per transaction on a valid/ready output.
- Used as the lab datapath block that replaces hand-instanced gate trees.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CNT_W, 4, width of the operand counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat.
- in_data  input  WIDTH  operand.
- in_op  input  3  gate select, sampled on the first beat only: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 reserved.
- in_last  input  1  final operand of the transaction.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  reduced result.
- out_cnt  output  CNT_W  number of operands consumed (saturating).
- out_err  output  1  reserved op was selected.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, acc=0, op_q=0, cnt=0, out_valid=0, out_data=0, out_cnt=0, out_err=0.
  - Reset overrides any handshake in the same cycle.
  - Reset mid-transaction discards the partial result; no output is produced for it.
- Beat transfer: a beat transfers when in_valid && in_ready at the edge.
- Result transfer: a result transfers when out_valid && out_ready at the edge.
- States:
  - IDLE: in_ready=1, out_valid=0. On a transfer: acc<=in_data, op_q<=in_op, cnt<=1. Go to OUT if in_last=1, otherwise to ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On a transfer: acc<=acc BASE in_data, cnt<=cnt+1 (holds at all-ones). Go to OUT if in_last=1. With no transfer, hold everything.
  - OUT: in_ready=0, out_valid=1. Hold out_data, out_cnt and out_err stable until a result transfer, then go to IDLE. No input beat is accepted in OUT (no bypass).
- BASE function by op_q:
  - AND for ops 0 and 3; OR for ops 1 and 4; XOR for ops 2 and 5.
  - Ops 3, 4 and 5 invert the final accumulator only (~acc). The inversion is never applied per beat.
  - Single-operand transaction: AND/OR/XOR return the operand unchanged; NAND/NOR/XNOR return ~operand.
- Reserved op (6 or 7): operands are consumed normally and cnt advances; result is out_data=0, out_err=1.
- Output registers: out_data, out_cnt and out_err are registered and loaded on the cycle the state machine enters OUT.
- Latency: last beat accepted at edge N gives out_valid=1 after edge N; the result is visible in cycle N+1.
- Throughput: one operand per cycle. Minimum transaction occupancy is 2 cycles (one input cycle, one output cycle with out_ready=1).
- Operand sampling: in_op is ignored on non-first beats. in_data is don't-care when in_valid=0.
- in_valid may deassert between beats of a transaction; the accumulator holds across the gap.
- Width: all logic is bitwise, with no carries. The counter saturates and does not wrap.

Decomposition:
- Shared package (or include file) holds:
  - op code constants OP_AND=0 … OP_XNOR=5;
  - state encodings S_IDLE, S_ACCUM, S_OUT;
  - the helper function is_inverting(op).
- One natural sub-module, bitwise_gate_core: a combinational WIDTH-bit 2-input AND/OR/XOR selected by a 2-bit base select. It is instanced once for the accumulator update.

Test Plan:
- NOR truth table, four 1-operand-pair transactions with WIDTH=8 and out_ready=1. Operands (0x00,0x00), (0x00,0xFF), (0xFF,0x00), (0xFF,0xFF) give out_data 0xFF, 0x00, 0x00, 0x00; out_cnt=2 each.
- 4-operand NAND: 0xFF, 0xF0, 0xFC, 0xF8 gives out_data=0x0F. 4-operand XOR: 0x01, 0x02, 0x04, 0x08 gives 0x0F, out_cnt=4.
- Backpressure: hold out_ready=0 for 5 cycles after the result. Required: out_valid stays 1, out_data stays stable, in_ready=0, and beats offered with in_valid=1 are not consumed. After out_ready=1, in_ready returns to 1 the next cycle.
- Gaps and reserved op:
  - in_valid toggling mid-transaction with OR over 0x01, 0x10, 0x80 gives 0x91.
  - op=6 over two beats gives out_data=0x00, out_err=1.
- Reset and saturation:
  - Assert rst after 2 of 3 beats. Required: out_valid=0 and state IDLE; a fresh single-beat AND of 0x5A then returns 0x5A.
  - With CNT_W=4, a 20-beat transaction returns out_cnt=15.
